// File: rtl/instr_encoder_loader_if.sv
// Request and instruction-memory write bus for the RV32I encoder/loader.
// The master side issues field-level requests and observes the imem write port.
interface instr_encoder_loader_if #(
  parameter int ADDR_W = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_class;
  logic [2:0]        in_funct3;
  logic              in_f7b5;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [31:0]       in_imm;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output in_valid, in_class, in_funct3, in_f7b5, in_rd, in_rs1, in_rs2, in_imm,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_class, in_funct3, in_f7b5, in_rd, in_rs1, in_rs2, in_imm,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Encodes RV32I instructions from field-level requests and streams them into
// instruction memory at consecutive word addresses, one word per cycle.
module instr_encoder_loader #(
  parameter int ADDR_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  instr_encoder_loader_if.slave bus,
  output logic [ADDR_W:0]       count,
  output logic                  full,
  output logic                  err_class,
  output logic                  err_imm
);

  typedef enum logic [2:0] {
    CLS_LOAD   = 3'd0,
    CLS_STORE  = 3'd1,
    CLS_R      = 3'd2,
    CLS_BRANCH = 3'd3,
    CLS_IALU   = 3'd4,
    CLS_JAL    = 3'd5
  } instr_class_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam int               DEPTH   = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]  DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W+1:0] DEPTH_O = (ADDR_W + 2)'(DEPTH);

  logic              pend_valid;
  logic [31:0]       pend_word;
  logic [ADDR_W-1:0] wr_ptr;

  logic              accept;
  logic [31:0]       word;
  logic              class_bad;
  logic              imm_bad;
  logic [ADDR_W+1:0] occupancy;
  logic signed [31:0] imm_s;
  logic              in_i_range;
  logic              in_b_range;
  logic              in_j_range;
  logic              is_shift;

  // The word waiting in stage 2 already owns a slot, so it counts toward capacity.
  assign occupancy    = {1'b0, count} + {{(ADDR_W + 1){1'b0}}, pend_valid};
  assign bus.in_ready = !rst && !clear && (occupancy < DEPTH_O);
  assign accept       = bus.in_valid && bus.in_ready;

  assign imm_s      = $signed(bus.in_imm);
  assign in_i_range = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
  assign in_b_range = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094) && !bus.in_imm[0];
  assign in_j_range = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574) && !bus.in_imm[0];
  assign is_shift   = (bus.in_funct3 == 3'b001) || (bus.in_funct3 == 3'b101);

  // Field assembly and immediate legality for the current request.
  always_comb begin
    word      = '0;
    class_bad = 1'b0;
    imm_bad   = 1'b0;
    case (instr_class_e'(bus.in_class))
      CLS_LOAD: begin
        word    = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, OP_LOAD};
        imm_bad = !in_i_range;
      end
      CLS_STORE: begin
        word    = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                   bus.in_imm[4:0], OP_STORE};
        imm_bad = !in_i_range;
      end
      CLS_R: begin
        word = {1'b0, bus.in_f7b5, 5'b00000, bus.in_rs2, bus.in_rs1, bus.in_funct3,
                bus.in_rd, OP_R};
      end
      CLS_BRANCH: begin
        word    = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1,
                   bus.in_funct3, bus.in_imm[4:1], bus.in_imm[11], OP_BRANCH};
        imm_bad = !in_b_range;
      end
      CLS_IALU: begin
        // Shifts reuse imm[11:5] as the funct7 field; only a 5-bit shamt is legal.
        if (is_shift) begin
          word    = {1'b0, bus.in_f7b5, 5'b00000, bus.in_imm[4:0], bus.in_rs1,
                     bus.in_funct3, bus.in_rd, OP_IALU};
          imm_bad = |bus.in_imm[31:5];
        end else begin
          word    = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, OP_IALU};
          imm_bad = !in_i_range;
        end
      end
      CLS_JAL: begin
        word    = {bus.in_imm[20], bus.in_imm[10:1], bus.in_imm[11], bus.in_imm[19:12],
                   bus.in_rd, OP_JAL};
        imm_bad = !in_j_range;
      end
      default: begin
        class_bad = 1'b1;
      end
    endcase
  end

  // Stage 2 register, write pointer, occupancy count and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      pend_valid <= 1'b0;
      pend_word  <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      err_class  <= 1'b0;
      err_imm    <= 1'b0;
    end else begin
      if (pend_valid) begin
        wr_ptr <= wr_ptr + 1'b1;
        count  <= count + 1'b1;
      end
      pend_valid <= accept && !class_bad && !imm_bad;
      if (accept && !class_bad && !imm_bad) begin
        pend_word <= word;
      end
      if (accept && class_bad) begin
        err_class <= 1'b1;
      end
      if (accept && imm_bad) begin
        err_imm <= 1'b1;
      end
    end
  end

  assign bus.imem_we    = pend_valid;
  assign bus.imem_addr  = wr_ptr;
  assign bus.imem_wdata = pend_word;
  assign full           = (count == DEPTH_C);

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader with a 4-word imem so the full/no-wrap
// boundary is reachable; expected words are hand-encoded RV32I instructions.
module tb_instr_encoder_loader;
  localparam int ADDR_W = 2;

  logic            clk;
  logic            rst;
  logic            clear;
  logic [ADDR_W:0] count;
  logic            full;
  logic            err_class;
  logic            err_imm;

  int checks;
  int errors;

  instr_encoder_loader_if #(.ADDR_W(ADDR_W)) bus ();

  instr_encoder_loader #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .bus       (bus),
    .count     (count),
    .full      (full),
    .err_class (err_class),
    .err_imm   (err_imm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one request and let a clock edge pass; outputs are then sampled 1ns later.
  task automatic apply_stimulus(input logic [2:0] cls, input logic [2:0] f3, input logic f7b5,
                                input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [31:0] imm);
    bus.in_valid  = 1'b1;
    bus.in_class  = cls;
    bus.in_funct3 = f3;
    bus.in_f7b5   = f7b5;
    bus.in_rd     = rd;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_imm    = imm;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    clear = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_class = '0;
    bus.in_funct3 = '0;
    bus.in_f7b5 = 1'b0;
    bus.in_rd = '0;
    bus.in_rs1 = '0;
    bus.in_rs2 = '0;
    bus.in_imm = '0;
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_we", 32'(bus.imem_we), 32'd0);
    check_output("rst_addr", 32'(bus.imem_addr), 32'd0);
    check_output("rst_wdata", bus.imem_wdata, 32'd0);
    check_output("rst_count", 32'(count), 32'd0);
    check_output("rst_full", 32'(full), 32'd0);
    check_output("rst_errs", {30'd0, err_class, err_imm}, 32'd0);
    check_output("rst_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    #1;
    check_output("ready_after_rst", 32'(bus.in_ready), 32'd1);

    // add x3,x1,x2
    apply_stimulus(3'd2, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0);
    check_output("add_we", 32'(bus.imem_we), 32'd1);
    check_output("add_addr", 32'(bus.imem_addr), 32'd0);
    check_output("add_wdata", bus.imem_wdata, 32'h002081B3);
    idle_cycle();
    check_output("add_we_drop", 32'(bus.imem_we), 32'd0);
    check_output("add_count", 32'(count), 32'd1);
    pulse_clear();
    check_output("clear_count", 32'(count), 32'd0);

    // lw x5,8(x2) then sw x6,12(x2) back to back
    apply_stimulus(3'd0, 3'd2, 1'b0, 5'd5, 5'd2, 5'd0, 32'd8);
    check_output("lw_we", 32'(bus.imem_we), 32'd1);
    check_output("lw_addr", 32'(bus.imem_addr), 32'd0);
    check_output("lw_wdata", bus.imem_wdata, 32'h00812283);
    apply_stimulus(3'd1, 3'd2, 1'b0, 5'd0, 5'd2, 5'd6, 32'd12);
    check_output("sw_we", 32'(bus.imem_we), 32'd1);
    check_output("sw_addr", 32'(bus.imem_addr), 32'd1);
    check_output("sw_wdata", bus.imem_wdata, 32'h00612623);
    check_output("sw_count", 32'(count), 32'd1);

    // beq x1,x2,-4 then jal x1,+8 fills the last two slots
    apply_stimulus(3'd3, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, -32'sd4);
    check_output("beq_addr", 32'(bus.imem_addr), 32'd2);
    check_output("beq_wdata", bus.imem_wdata, 32'hFE208EE3);
    apply_stimulus(3'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8);
    check_output("jal_addr", 32'(bus.imem_addr), 32'd3);
    check_output("jal_wdata", bus.imem_wdata, 32'h008000EF);
    check_output("jal_count", 32'(count), 32'd3);
    check_output("pending_blocks_ready", 32'(bus.in_ready), 32'd0);
    idle_cycle();
    check_output("full_count", 32'(count), 32'd4);
    check_output("full_flag", 32'(full), 32'd1);
    pulse_clear();
    check_output("clear_full", 32'(full), 32'd0);

    // srai x3,x1,4
    apply_stimulus(3'd4, 3'd5, 1'b1, 5'd3, 5'd1, 5'd0, 32'd4);
    check_output("srai_wdata", bus.imem_wdata, 32'h4040D193);
    idle_cycle();

    // Bad immediates and an illegal class are consumed without writing
    apply_stimulus(3'd4, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048);
    check_output("addi2048_we", 32'(bus.imem_we), 32'd0);
    check_output("addi2048_err", 32'(err_imm), 32'd1);
    apply_stimulus(3'd3, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3);
    check_output("beq_odd_we", 32'(bus.imem_we), 32'd0);
    apply_stimulus(3'd4, 3'd1, 1'b0, 5'd1, 5'd1, 5'd0, 32'd32);
    check_output("slli32_we", 32'(bus.imem_we), 32'd0);
    check_output("bad_imm_count", 32'(count), 32'd1);
    check_output("no_class_err_yet", 32'(err_class), 32'd0);
    apply_stimulus(3'd6, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0);
    check_output("class6_we", 32'(bus.imem_we), 32'd0);
    check_output("class6_err", 32'(err_class), 32'd1);
    idle_cycle();
    idle_cycle();
    check_output("errs_sticky", {30'd0, err_class, err_imm}, 32'd3);
    check_output("errs_count", 32'(count), 32'd1);
    pulse_clear();
    check_output("clear_errs", {30'd0, err_class, err_imm}, 32'd0);
    check_output("clear_count2", 32'(count), 32'd0);

    // Fill to capacity with requests held back to back; no wrap past full
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(3'd2, 3'd0, 1'b0, 5'(k + 1), 5'd1, 5'd2, 32'd0);
      check_output($sformatf("fill%0d_addr", k), 32'(bus.imem_addr), 32'(k));
    end
    check_output("fill_ready_low", 32'(bus.in_ready), 32'd0);
    // addi x1,x0,-2048 waits behind the full memory
    apply_stimulus(3'd4, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, -32'sd2048);
    check_output("fifth_we", 32'(bus.imem_we), 32'd0);
    check_output("fifth_count", 32'(count), 32'd4);
    check_output("fifth_full", 32'(full), 32'd1);
    @(posedge clk);
    #1;
    check_output("held_we", 32'(bus.imem_we), 32'd0);
    check_output("held_ready", 32'(bus.in_ready), 32'd0);
    pulse_clear();
    check_output("clr_full_count", 32'(count), 32'd0);
    check_output("clr_full_we", 32'(bus.imem_we), 32'd0);
    @(posedge clk);
    #1;
    check_output("after_clear_we", 32'(bus.imem_we), 32'd1);
    check_output("after_clear_addr", 32'(bus.imem_addr), 32'd0);
    check_output("after_clear_wdata", bus.imem_wdata, 32'h80000093);
    idle_cycle();
    check_output("after_clear_count", 32'(count), 32'd1);

    // Reset while a write is pending drops it
    apply_stimulus(3'd2, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0);
    check_output("pre_rst_we", 32'(bus.imem_we), 32'd1);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_output("rst_pend_we", 32'(bus.imem_we), 32'd0);
    check_output("rst_pend_count", 32'(count), 32'd0);
    check_output("rst_pend_addr", 32'(bus.imem_addr), 32'd0);
    check_output("rst_pend_wdata", bus.imem_wdata, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_output("rst_pend_after_we", 32'(bus.imem_we), 32'd0);
    check_output("rst_pend_after_count", 32'(count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
